matmul_seq_ctrl: RTL



---
 rtl/matmul_pkg.sv | 19 +
 rtl/multiply.sv | 20 ++
 rtl/matmul_seq_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the sequential matrix-multiply controller.
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  // Width of one C element: a full product plus headroom for Ndata additions.
  function automatic int unsigned cbits(input int unsigned ndata, input int unsigned nbits);
    return 2 * nbits + $clog2(ndata);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiply.sv
// Ndata-lane unsigned multiply array: lane k computes a[k] * b[k] combinationally.
module multiply #(
  parameter int unsigned Ndata = 4,
  parameter int unsigned Nbits = 8
) (
  input  logic [Ndata*Nbits-1:0]   a_i,
  input  logic [Ndata*Nbits-1:0]   b_i,
  output logic [Ndata*2*Nbits-1:0] p_o
);

  localparam int unsigned ProdW = 2 * Nbits;

  always_comb begin
    p_o = '0;
    for (int unsigned k = 0; k < Ndata; k++) begin
      p_o[k*ProdW +: ProdW] = ProdW'(a_i[k*Nbits +: Nbits]) * ProdW'(b_i[k*Nbits +: Nbits]);
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer computing C = A*B one dot product per cycle on a shared multiply array,
// streaming C row-major over a valid/ready interface.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned Ndata = 4,
  parameter int unsigned Nbits = 8,
  parameter int unsigned Cbits = cbits(Ndata, Nbits),
  localparam int unsigned IdxW = idx_w(Ndata)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [Ndata*Ndata*Nbits-1:0] mat_a,
  input  logic [Ndata*Ndata*Nbits-1:0] mat_b,
  output logic                         busy,
  output logic                         done,
  output logic [Cbits-1:0]             c_data,
  output logic [IdxW-1:0]              c_row,
  output logic [IdxW-1:0]              c_col,
  output logic                         c_valid,
  input  logic                         c_ready
);

  localparam int unsigned MatW  = Ndata * Ndata * Nbits;
  localparam int unsigned LaneW = Ndata * Nbits;
  localparam int unsigned ProdW = 2 * Nbits;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ndata - 1);

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          i_q, i_d, j_q, j_d;
  logic [MatW-1:0]          a_q, a_d, b_q, b_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [Ndata*ProdW-1:0]   s1_prod_q, s1_prod_d;
  logic [IdxW-1:0]          s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic                     c_valid_q, c_valid_d;
  logic [Cbits-1:0]         c_data_q, c_data_d;
  logic [IdxW-1:0]          c_row_q, c_row_d, c_col_q, c_col_d;
  logic                     done_q, done_d;

  logic [LaneW-1:0]         lane_a, lane_b;
  logic [Ndata*ProdW-1:0]   lane_p;
  logic [Cbits-1:0]         dot;
  logic                     adv, issue, last_accept;

  assign adv   = !c_valid_q || c_ready;
  assign issue = (state_q == StRun) && adv;
  assign last_accept = c_valid_q && c_ready && (c_row_q == LastIdx) && (c_col_q == LastIdx);

  // Row i of A lane-by-lane; column j of B gathered across rows.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int unsigned k = 0; k < Ndata; k++) begin
      lane_a[k*Nbits +: Nbits] = a_q[(32'(i_q) * Ndata + k) * Nbits +: Nbits];
      lane_b[k*Nbits +: Nbits] = b_q[(k * Ndata + 32'(j_q)) * Nbits +: Nbits];
    end
  end

  multiply #(
    .Ndata (Ndata),
    .Nbits (Nbits)
  ) u_multiply (
    .a_i (lane_a),
    .b_i (lane_b),
    .p_o (lane_p)
  );

  always_comb begin
    dot = '0;
    for (int unsigned k = 0; k < Ndata; k++) begin
      dot = dot + Cbits'(s1_prod_q[k*ProdW +: ProdW]);
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;
    c_valid_d  = c_valid_q;
    c_data_d   = c_data_q;
    c_row_d    = c_row_q;
    c_col_d    = c_col_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = mat_a;
          b_d     = mat_b;
          i_d     = '0;
          j_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (adv) begin
          if (j_q == LastIdx) begin
            j_d = '0;
            if (i_q == LastIdx) begin
              i_d     = '0;
              state_d = StFlush;
            end else begin
              i_d = i_q + IdxW'(1);
            end
          end else begin
            j_d = j_q + IdxW'(1);
          end
        end
      end
      StFlush: begin
        if (last_accept) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Both pipeline stages move together; a stalled output freezes everything upstream.
    if (adv) begin
      s1_valid_d = issue;
      if (issue) begin
        s1_prod_d = lane_p;
        s1_row_d  = i_q;
        s1_col_d  = j_q;
      end
      c_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        c_data_d = dot;
        c_row_d  = s1_row_q;
        c_col_d  = s1_col_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      i_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      c_valid_q  <= 1'b0;
      c_data_q   <= '0;
      c_row_q    <= '0;
      c_col_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      c_valid_q  <= c_valid_d;
      c_data_q   <= c_data_d;
      c_row_q    <= c_row_d;
      c_col_q    <= c_col_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign c_data  = c_data_q;
  assign c_row   = c_row_q;
  assign c_col   = c_col_q;
  assign c_valid = c_valid_q;

endmodule
